iserdes2_bitslip_train: RTL and testbench

- Alignment controller for the two-lane ISERDES2 deserializer PHY (lane A and lane B, each DATA_WIDTH bits per clkdiv word).
- After a start pulse, it trains lane A and then lane B against a fixed training word.
- Training issues single-cycle bitslip pulses and drives the per-lane bit-reversal flags until each lane's deserialized word matches the pattern for a run of consecutive cycles.
- Reports per-lane lock/error status to system control logic.

---
 rtl/iserdes2_pkg.sv | 19 +
 rtl/iserdes2_bitslip_train.sv | 180 ++++++++++++++++++
 tb/tb_iserdes2_bitslip_train.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iserdes2_pkg.sv
// Shared constants for the ISERDES2 two-lane bitslip training controller:
// FSM state encoding, lane indices and the default training word.
`timescale 1ns/1ps
package iserdes2_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_SLIP   = 3'd3;
    localparam logic [2:0] ST_NEXT   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_FAIL   = 3'd6;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'hA5;

endpackage

// File: rtl/iserdes2_bitslip_train.sv
// Two-lane ISERDES2 alignment controller: one FSM trains lane A then lane B by
// bitslipping and bit-order reversal until the training word holds steady.
`timescale 1ns/1ps
module iserdes2_bitslip_train
    import iserdes2_pkg::*;
#(
    parameter int         DATA_WIDTH    = 8,
    parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MATCH_COUNT   = 16
) (
    input  logic                  clkdiv,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] word_a,
    input  logic [DATA_WIDTH-1:0] word_b,
    output logic                  bitslip_a,
    output logic                  bitslip_b,
    output logic                  reva_flag,
    output logic                  revb_flag,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            locked,
    output logic [1:0]            err
);

    localparam int SW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [SW-1:0]         SLIP_LAST   = SW'(DATA_WIDTH - 1);
    localparam logic [3:0]            SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]            MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [DATA_WIDTH-1:0] PATTERN     = TRAIN_PATTERN[DATA_WIDTH-1:0];

    logic [2:0]    state_q, state_d;
    logic          lane_q, lane_d;
    logic [SW-1:0] slip_cnt_q, slip_cnt_d;
    logic [3:0]    settle_cnt_q, settle_cnt_d;
    logic [7:0]    match_cnt_q, match_cnt_d;
    logic [1:0]    rev_q, rev_d;
    logic [1:0]    locked_q, locked_d;
    logic [1:0]    err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bitslip_a_q, bitslip_a_d;
    logic          bitslip_b_q, bitslip_b_d;

    logic [DATA_WIDTH-1:0] lane_word;
    logic                  word_ok;

    assign lane_word = (lane_q == LANE_B) ? word_b : word_a;
    assign word_ok   = (lane_word == PATTERN);

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        slip_cnt_d   = slip_cnt_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        rev_d        = rev_q;
        locked_d     = locked_q;
        err_d        = err_q;
        busy_d       = busy_q;
        done_d       = done_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d      = ST_SETTLE;
                    lane_d       = LANE_A;
                    slip_cnt_d   = '0;
                    settle_cnt_d = '0;
                    match_cnt_d  = '0;
                    rev_d        = '0;
                    locked_d     = '0;
                    err_d        = '0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = '0;
                    match_cnt_d  = '0;
                    state_d      = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            ST_CHECK: begin
                if (word_ok) begin
                    if (match_cnt_q == MATCH_LAST) begin
                        locked_d[lane_q] = 1'b1;
                        match_cnt_d      = '0;
                        state_d          = ST_NEXT;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                end else begin
                    // Any bad word ends the run; the lock needs a fresh full run.
                    match_cnt_d = '0;
                    if (slip_cnt_q < SLIP_LAST) begin
                        state_d = ST_SLIP;
                    end else if (!rev_q[lane_q]) begin
                        rev_d[lane_q] = 1'b1;
                        slip_cnt_d    = '0;
                        state_d       = ST_SETTLE;
                    end else begin
                        err_d[lane_q] = 1'b1;
                        state_d       = ST_NEXT;
                    end
                end
            end
            ST_SLIP: begin
                slip_cnt_d = slip_cnt_q + 1'b1;
                state_d    = ST_SETTLE;
            end
            ST_NEXT: begin
                if (lane_q == LANE_A) begin
                    lane_d     = LANE_B;
                    slip_cnt_d = '0;
                    state_d    = ST_SETTLE;
                end else begin
                    busy_d = 1'b0;
                    if (err_q == 2'b00) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pulses are registered from the next state so they align with SLIP.
        bitslip_a_d = (state_d == ST_SLIP) && (lane_d == LANE_A);
        bitslip_b_d = (state_d == ST_SLIP) && (lane_d == LANE_B);
    end

    always_ff @(posedge clkdiv or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            lane_q       <= LANE_A;
            slip_cnt_q   <= '0;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            rev_q        <= '0;
            locked_q     <= '0;
            err_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bitslip_a_q  <= 1'b0;
            bitslip_b_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            slip_cnt_q   <= slip_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            rev_q        <= rev_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bitslip_a_q  <= bitslip_a_d;
            bitslip_b_q  <= bitslip_b_d;
        end
    end

    assign bitslip_a = bitslip_a_q;
    assign bitslip_b = bitslip_b_q;
    assign reva_flag = rev_q[LANE_A];
    assign revb_flag = rev_q[LANE_B];
    assign busy      = busy_q;
    assign done      = done_q;
    assign locked    = locked_q;
    assign err       = err_q;

endmodule

// File: tb/tb_iserdes2_bitslip_train.sv
// Bench for iserdes2_bitslip_train: a behavioural PHY (rotation + optional
// native reversal) feeds both lanes; outcomes come from a per-lane timing model.
`timescale 1ns/1ps
module tb_iserdes2_bitslip_train;

    localparam int         DW  = 8;
    localparam logic [7:0] PAT = 8'h35;

    logic          clkdiv = 1'b0;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] word_a, word_b;
    logic          bitslip_a, bitslip_b, reva_flag, revb_flag, busy, done;
    logic [1:0]    locked, err;

    int tests = 0;
    int fails = 0;

    // PHY model configuration (written only by the stimulus block)
    int need_v[2];
    bit nrev_v[2];
    bit stuck_v[2];
    bit noslip_v[2];
    bit corrupt_a;
    int run_id = 0;

    // PHY model state and monitors (written only by the negedge block)
    int slips[2];
    int pulses[2];
    int gap_viol, both_viol, since_pulse;
    int last_run = 0;

    iserdes2_bitslip_train #(
        .DATA_WIDTH(DW), .TRAIN_PATTERN(PAT), .SETTLE_CYCLES(4), .MATCH_COUNT(16)
    ) dut (
        .clkdiv(clkdiv), .reset_n(reset_n), .start(start),
        .word_a(word_a), .word_b(word_b),
        .bitslip_a(bitslip_a), .bitslip_b(bitslip_b),
        .reva_flag(reva_flag), .revb_flag(revb_flag),
        .busy(busy), .done(done), .locked(locked), .err(err)
    );

    always #5 clkdiv = ~clkdiv;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        int kk;
        kk = ((k % 8) + 8) % 8;
        if (kk == 0) return v;
        return (v << kk) | (v >> (8 - kk));
    endfunction

    // Word seen by the controller: aligned once the slip count equals 'need'
    // and the reversal flag equals the lane's native bit order.
    function automatic logic [7:0] phy_word(input int need, input bit nrev, input bit stuck,
                                            input bit noslip, input int sl, input bit rev);
        logic [7:0] src, raw;
        if (stuck) return 8'h00;
        src = nrev ? bitrev8(PAT) : PAT;
        raw = rotl8(src, noslip ? 0 : (sl - need));
        return rev ? bitrev8(raw) : raw;
    endfunction

    always @(negedge clkdiv) begin
        if (run_id != last_run) begin
            last_run    = run_id;
            slips[0]    = 0;
            slips[1]    = 0;
            pulses[0]   = 0;
            pulses[1]   = 0;
            gap_viol    = 0;
            both_viol   = 0;
            since_pulse = 100;
        end
        if (bitslip_a === 1'b1) begin slips[0]++; pulses[0]++; end
        if (bitslip_b === 1'b1) begin slips[1]++; pulses[1]++; end
        if (bitslip_a === 1'b1 && bitslip_b === 1'b1) both_viol++;
        if (bitslip_a === 1'b1 || bitslip_b === 1'b1) begin
            if (since_pulse < 4) gap_viol++;
            since_pulse = 0;
        end else begin
            since_pulse++;
        end
        word_a = phy_word(need_v[0], nrev_v[0], stuck_v[0], noslip_v[0], slips[0], reva_flag === 1'b1)
                 ^ (corrupt_a ? 8'hFF : 8'h00);
        word_b = phy_word(need_v[1], nrev_v[1], stuck_v[1], noslip_v[1], slips[1], revb_flag === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-lane outcome from the training rules: each failed position costs
    // check+slip+settle (6), a bit-order flip costs check+settle (5),
    // a lock costs 16 checks + NEXT, a give-up costs one check + NEXT.
    function automatic void lane_model(input int n, input bit r, input bit s,
                                       output int cyc, output int sl, output bit rev, output bit lk);
        if (s) begin
            sl = 14; rev = 1'b1; lk = 1'b0; cyc = 4 + 6 * sl + 5 + 2;
        end else if (!r) begin
            sl = n; rev = 1'b0; lk = 1'b1; cyc = 4 + 6 * sl + 17;
        end else begin
            sl = 7 + ((n + 1) % 8); rev = 1'b1; lk = 1'b1; cyc = 4 + 6 * sl + 5 + 17;
        end
    endfunction

    task automatic set_phy(input int na, input bit ra, input bit sa, input bit nsa,
                           input int nb, input bit rb, input bit sb);
        need_v[0] = na; nrev_v[0] = ra; stuck_v[0] = sa; noslip_v[0] = nsa;
        need_v[1] = nb; nrev_v[1] = rb; stuck_v[1] = sb; noslip_v[1] = 1'b0;
    endtask

    task automatic train(input int restart_at, input int corrupt_at, output int cyc);
        run_id++;
        start = 1'b1;
        @(posedge clkdiv); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("cleared_after_start", {27'd0, done, locked, err}, 32'd0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 1000) begin
            corrupt_a = (corrupt_at >= 0 && cyc == corrupt_at);
            start     = (restart_at >= 0 && cyc == restart_at);
            @(posedge clkdiv); #1;
            cyc++;
        end
        corrupt_a = 1'b0;
        start     = 1'b0;
        chk("train_timeout", {31'd0, cyc < 1000}, 32'd1);
    endtask

    task automatic check_run(input string tag, input int cyc, input int na, input bit ra,
                             input bit sa, input int nb, input bit rb, input bit sb);
        int ca, cb, sla, slb;
        bit rva, rvb, lka, lkb;
        lane_model(na, ra, sa, ca, sla, rva, lka);
        lane_model(nb, rb, sb, cb, slb, rvb, lkb);
        chk($sformatf("%s_cycles", tag), cyc, ca + cb);
        chk($sformatf("%s_pulses_a", tag), pulses[0], sla);
        chk($sformatf("%s_pulses_b", tag), pulses[1], slb);
        chk($sformatf("%s_reva", tag), {31'd0, reva_flag}, {31'd0, rva});
        chk($sformatf("%s_revb", tag), {31'd0, revb_flag}, {31'd0, rvb});
        chk($sformatf("%s_locked", tag), {30'd0, locked}, {30'd0, lkb, lka});
        chk($sformatf("%s_err", tag), {30'd0, err}, {30'd0, !lkb, !lka});
        chk($sformatf("%s_done", tag), {31'd0, done}, {31'd0, lka & lkb});
        chk($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s_overlap", tag), both_viol, 0);
        chk($sformatf("%s_gap", tag), gap_viol, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, k, na, nb;
        bit ra, rb, sa;
        reset_n   = 1'b0;
        start     = 1'b0;
        corrupt_a = 1'b0;
        set_phy(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clkdiv);
        chk("reset_outputs", {20'd0, bitslip_a, bitslip_b, reva_flag, revb_flag, busy, done, locked, err}, 32'd0);
        reset_n = 1'b1;
        @(posedge clkdiv); #1;

        // Both lanes aligned
        set_phy(0, 0, 0, 0, 0, 0, 0);
        train(-1, -1, cyc);
        chk("aligned_cycles_42", cyc, 42);
        check_run("aligned", cyc, 0, 0, 0, 0, 0, 0);

        // Lane A needs three slips
        set_phy(3, 0, 0, 0, 0, 0, 0);
        train(-1, -1, cyc);
        check_run("rot3_a", cyc, 3, 0, 0, 0, 0, 0);

        // Lane B only aligns reversed after the full first slip sweep
        set_phy(0, 0, 0, 0, 7, 1, 0);
        train(-1, -1, cyc);
        chk("revb_pulses_7", pulses[1], 7);
        check_run("rev_b", cyc, 0, 0, 0, 7, 1, 0);

        // Lane A never matches
        set_phy(0, 0, 1, 0, 0, 0, 0);
        train(-1, -1, cyc);
        chk("stuck_pulses_14", pulses[0], 14);
        check_run("stuck_a", cyc, 0, 0, 1, 0, 0, 0);

        // Match run broken after 10 good words; PHY word stays aligned
        set_phy(0, 0, 0, 1, 0, 0, 0);
        train(-1, 14, cyc);
        chk("broken_cycles", cyc, 37 + 21);
        chk("broken_pulses_a", pulses[0], 1);
        chk("broken_pulses_b", pulses[1], 0);
        chk("broken_locked", {30'd0, locked}, 32'd3);
        chk("broken_done", {31'd0, done}, 32'd1);

        // Start while busy is ignored
        set_phy(2, 0, 0, 0, 0, 0, 0);
        train(20, -1, cyc);
        check_run("restart_busy", cyc, 2, 0, 0, 0, 0, 0);

        // Randomized lane conditions
        for (int it = 0; it < 8; it++) begin
            na = $urandom_range(0, 7);
            nb = $urandom_range(0, 7);
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            sa = ($urandom_range(0, 5) == 0);
            set_phy(na, ra, sa, 0, nb, rb, 0);
            train(-1, -1, cyc);
            check_run($sformatf("rand%0d", it), cyc, na, ra, sa, nb, rb, 0);
        end

        // Reset asserted while a bitslip pulse is high
        set_phy(3, 0, 0, 0, 0, 0, 0);
        run_id++;
        start = 1'b1;
        @(posedge clkdiv); #1;
        start = 1'b0;
        k = 0;
        while (bitslip_a !== 1'b1 && k < 50) begin
            @(posedge clkdiv); #1;
            k++;
        end
        chk("slip_seen_before_reset", {31'd0, bitslip_a}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_slip", {20'd0, bitslip_a, bitslip_b, reva_flag, revb_flag, busy, done, locked, err}, 32'd0);
        @(negedge clkdiv);
        reset_n = 1'b1;
        repeat (3) @(posedge clkdiv);
        #1;
        chk("idle_after_reset", {30'd0, busy, bitslip_a}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
